axi_mem_arbiter: RTL and testbench

Two-requester, single-outstanding-transaction sequencer for the CPU's AXI4 master port. It accepts load/store requests from two internal clients (port 0 and port 1, e.g. fetch and data memory) and arbitrates between them round-robin. It drives the AXI address, data and valid/ready handshakes for single-beat transfers, and returns read data or write completion to the granted client. The burst, size, ID, cache and strobe attributes of each transfer are fixed by the static AXI configuration tie-offs. BREADY is tied high by that configuration, so this block only observes BVALID/BRESP.

---
 rtl/axi_mem_arbiter_if.sv | 67 ++++++
 rtl/axi_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_arbiter_if.sv
// rtl/axi_mem_arbiter_if.sv - client request/response and single-beat AXI bus bundle
// Purpose: groups both client ports and the AXI4 read/write channels of the arbiter.
// Ports (modport master = arbiter side):
//   req0_*/req1_*    client requests (valid, we, addr, wdata) in, ready out
//   resp0_*/resp1_*  completion pulse, read data, error out
//   aw*/w*/b*        AXI write address/data/response channels
//   ar*/r*           AXI read address/data channels
// modport slave is the mirror image (clients plus AXI slave).

interface axi_mem_arbiter_if #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32
);
    logic                        req0_valid;
    logic                        req0_we;
    logic [C_AXI_ADDR_WIDTH-1:0] req0_addr;
    logic [C_AXI_DATA_WIDTH-1:0] req0_wdata;
    logic                        req0_ready;
    logic                        resp0_valid;
    logic [C_AXI_DATA_WIDTH-1:0] resp0_data;
    logic                        resp0_err;

    logic                        req1_valid;
    logic                        req1_we;
    logic [C_AXI_ADDR_WIDTH-1:0] req1_addr;
    logic [C_AXI_DATA_WIDTH-1:0] req1_wdata;
    logic                        req1_ready;
    logic                        resp1_valid;
    logic [C_AXI_DATA_WIDTH-1:0] resp1_data;
    logic                        resp1_err;

    logic [C_AXI_ADDR_WIDTH-1:0] awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [C_AXI_DATA_WIDTH-1:0] wdata;
    logic                        wlast;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic [C_AXI_ADDR_WIDTH-1:0] araddr;
    logic                        arvalid;
    logic                        arready;
    logic [C_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_data, resp0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_data, resp1_err,
        output awaddr, awvalid, wdata, wlast, wvalid, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_data, resp0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_data, resp1_err,
        input  awaddr, awvalid, wdata, wlast, wvalid, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - two-client round-robin sequencer for single-beat AXI transfers
// Purpose: grants one of two clients, runs one outstanding single-beat AXI read or
// write, and returns a one-cycle completion pulse to the granted client.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  axi_mem_arbiter_if.master: client request/response ports and AXI channels

module axi_mem_arbiter #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_mem_arbiter_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP
    } state_t;

    state_t                      state;
    logic                        ptr;
    logic                        owner;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
    logic                        aw_done;
    logic                        w_done;

    logic                        arvalid_q;
    logic                        awvalid_q;
    logic                        wvalid_q;
    logic                        rready_q;
    logic                        resp0_valid_q;
    logic [C_AXI_DATA_WIDTH-1:0] resp0_data_q;
    logic                        resp0_err_q;
    logic                        resp1_valid_q;
    logic [C_AXI_DATA_WIDTH-1:0] resp1_data_q;
    logic                        resp1_err_q;

    logic grant0;
    logic grant1;
    logic aw_hs;
    logic w_hs;

    // A lone requester wins regardless of the pointer; on contention the pointer decides.
    // Held off during reset so no acceptance is signalled that the FSM would not latch.
    assign grant0 = !rst && (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr);
    assign grant1 = !rst && (state == IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr);

    assign aw_hs = awvalid_q && bus.awready;
    assign w_hs  = wvalid_q  && bus.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            owner         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            arvalid_q     <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            rready_q      <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp0_err_q   <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp1_data_q  <= '0;
            resp1_err_q   <= 1'b0;
        end else begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner   <= grant1;
                        ptr     <= !grant1;
                        addr_q  <= grant1 ? bus.req1_addr  : bus.req0_addr;
                        wdata_q <= grant1 ? bus.req1_wdata : bus.req0_wdata;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (grant1 ? bus.req1_we : bus.req0_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        if (owner) begin
                            resp1_valid_q <= 1'b1;
                            resp1_data_q  <= bus.rdata;
                            resp1_err_q   <= bus.rresp[1];
                        end else begin
                            resp0_valid_q <= 1'b1;
                            resp0_data_q  <= bus.rdata;
                            resp0_err_q   <= bus.rresp[1];
                        end
                        state <= IDLE;
                    end
                end

                WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    // Both channels may complete together or in either order.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bus.bvalid) begin
                        if (owner) begin
                            resp1_valid_q <= 1'b1;
                            resp1_data_q  <= '0;
                            resp1_err_q   <= bus.bresp[1];
                        end else begin
                            resp0_valid_q <= 1'b1;
                            resp0_data_q  <= '0;
                            resp0_err_q   <= bus.bresp[1];
                        end
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp0_data  = resp0_data_q;
    assign bus.resp0_err   = resp0_err_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp1_data  = resp1_data_q;
    assign bus.resp1_err   = resp1_err_q;

    assign bus.araddr  = addr_q;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;
    assign bus.awaddr  = addr_q;
    assign bus.awvalid = awvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.wlast   = wvalid_q;

    // EXOKAY bits and RLAST carry no information for single-beat transfers.
    logic unused_inputs;
    assign unused_inputs = ^{bus.rlast, bus.rresp[0], bus.bresp[0]};

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed self-checking bench for axi_mem_arbiter

module tb_axi_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] last_resp0;

    axi_mem_arbiter_if #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32)) bus ();

    axi_mem_arbiter #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.awready = 0; bus.wready = 0; bus.bresp = 2'b00; bus.bvalid = 0;
        bus.arready = 0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 0; bus.rvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic set_req(input int port, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    task automatic chk_resp(input string tag, input int port, input logic [31:0] d, input logic e);
        if (port == 0) begin
            chk({tag, "_resp0_valid"}, bus.resp0_valid, 1);
            chk({tag, "_resp1_quiet"}, bus.resp1_valid, 0);
            chk({tag, "_resp0_data"},  bus.resp0_data, d);
            chk({tag, "_resp0_err"},   bus.resp0_err, e);
        end else begin
            chk({tag, "_resp1_valid"}, bus.resp1_valid, 1);
            chk({tag, "_resp0_quiet"}, bus.resp0_valid, 0);
            chk({tag, "_resp1_data"},  bus.resp1_data, d);
            chk({tag, "_resp1_err"},   bus.resp1_err, e);
        end
    endtask

    // Zero-wait read: grant at G, AR at G+1, R at G+2, response at G+3.
    task automatic do_read(input string tag, input int port, input logic [31:0] a,
                           input logic [31:0] rd, input logic [1:0] rr, input logic exp_err);
        set_req(port, 1, 0, a, 32'h0);
        settle();
        chk({tag, "_grant"},  port == 0 ? bus.req0_ready : bus.req1_ready, 1);
        chk({tag, "_nogrant"}, port == 0 ? bus.req1_ready : bus.req0_ready, 0);
        cyc();
        set_req(port, 0, 0, 32'h0, 32'h0);
        chk({tag, "_arvalid"}, bus.arvalid, 1);
        chk({tag, "_araddr"},  bus.araddr, a);
        bus.arready = 1;
        cyc();
        bus.arready = 0;
        chk({tag, "_rready"}, bus.rready, 1);
        bus.rvalid = 1; bus.rdata = rd; bus.rresp = rr; bus.rlast = 1;
        cyc();
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = 2'b00;
        chk_resp(tag, port, rd, exp_err);
    endtask

    // Zero-wait write: grant at G, AW+W at G+1, B at G+2, response at G+3.
    task automatic do_write(input string tag, input int port, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] br, input logic exp_err);
        set_req(port, 1, 1, a, wd);
        settle();
        chk({tag, "_grant"}, port == 0 ? bus.req0_ready : bus.req1_ready, 1);
        cyc();
        set_req(port, 0, 0, 32'h0, 32'h0);
        chk({tag, "_awvalid"}, bus.awvalid, 1);
        chk({tag, "_wvalid"},  bus.wvalid, 1);
        chk({tag, "_awaddr"},  bus.awaddr, a);
        chk({tag, "_wdata"},   bus.wdata, wd);
        bus.awready = 1; bus.wready = 1;
        cyc();
        bus.awready = 0; bus.wready = 0;
        chk({tag, "_aw_dropped"}, bus.awvalid, 0);
        bus.bvalid = 1; bus.bresp = br;
        cyc();
        bus.bvalid = 0; bus.bresp = 2'b00;
        chk_resp(tag, port, 32'h0, exp_err);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1;
        clear_inputs();

        // Reset values
        do_reset();
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid",  bus.wvalid, 0);
        chk("rst_wlast",   bus.wlast, 0);
        chk("rst_rready",  bus.rready, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_resp0_valid", bus.resp0_valid, 0);
        chk("rst_resp1_valid", bus.resp1_valid, 0);
        chk("rst_resp0_data",  bus.resp0_data, 0);
        chk("rst_resp1_err",   bus.resp1_err, 0);

        // Single zero-wait read on port 0
        do_read("rd0", 0, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 0);
        cyc();
        chk("rd0_pulse_one_cycle", bus.resp0_valid, 0);
        chk("rd0_data_held", bus.resp0_data, 32'hDEAD_BEEF);

        // Contention: grants alternate 0,1,0,1 from a fresh pointer
        do_reset();
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 32'h0000_0100;
        bus.req1_valid = 1; bus.req1_we = 1; bus.req1_addr = 32'h0000_0020;
        bus.req1_wdata = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_req0_ready", bus.req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_req1_ready", bus.req1_ready, (k % 2 == 1) ? 1 : 0);
            cyc();
            chk("rr_busy_ready", {bus.req0_ready, bus.req1_ready}, 0);
            if (k % 2 == 0) begin
                chk("rr_arvalid", bus.arvalid, 1);
                chk("rr_araddr",  bus.araddr, 32'h0000_0100);
                bus.arready = 1;
            end else begin
                chk("rr_awvalid", bus.awvalid, 1);
                chk("rr_wvalid",  bus.wvalid, 1);
                chk("rr_wlast",   bus.wlast, 1);
                chk("rr_awaddr",  bus.awaddr, 32'h0000_0020);
                chk("rr_wdata",   bus.wdata, 32'h1234_5678);
                bus.awready = 1; bus.wready = 1;
            end
            cyc();
            bus.arready = 0; bus.awready = 0; bus.wready = 0;
            if (k % 2 == 0) begin
                bus.rvalid = 1; bus.rdata = 32'h1000_0000 + k; bus.rresp = 2'b00;
            end else begin
                bus.bvalid = 1; bus.bresp = 2'b00;
            end
            cyc();
            bus.rvalid = 0; bus.bvalid = 0;
            if (k % 2 == 0) chk_resp("rr", 0, 32'h1000_0000 + k, 0);
            else            chk_resp("rr", 1, 32'h0, 0);
        end
        last_resp0 = 32'h1000_0002;
        bus.req0_valid = 0; bus.req1_valid = 0;
        cyc();

        // Split write handshake on port 1: AW at G+1, W at G+4
        set_req(1, 1, 1, 32'h0000_0080, 32'hA5A5_0001);
        settle();
        chk("split_grant", bus.req1_ready, 1);
        cyc();
        set_req(1, 0, 0, 32'h0, 32'h0);
        chk("split_aw_g1", bus.awvalid, 1);
        chk("split_w_g1",  bus.wvalid, 1);
        bus.awready = 1;
        cyc();
        bus.awready = 0;
        chk("split_aw_g2", bus.awvalid, 0);
        chk("split_w_g2",  bus.wvalid, 1);
        chk("split_wdata_g2", bus.wdata, 32'hA5A5_0001);
        cyc();
        chk("split_w_g3",  bus.wvalid, 1);
        chk("split_wlast_g3", bus.wlast, 1);
        cyc();
        chk("split_w_g4",  bus.wvalid, 1);
        chk("split_wdata_g4", bus.wdata, 32'hA5A5_0001);
        bus.wready = 1;
        cyc();
        bus.wready = 0;
        chk("split_w_g5",  bus.wvalid, 0);
        chk("split_no_early_resp", bus.resp1_valid, 0);
        bus.bvalid = 1; bus.bresp = 2'b00;
        cyc();
        bus.bvalid = 0;
        chk_resp("split", 1, 32'h0, 0);
        chk("split_resp0_held", bus.resp0_data, last_resp0);

        // Slave error reporting, EXOKAY ignored
        do_read("err_rd", 0, 32'h0000_0200, 32'h0BAD_0001, 2'b10, 1);
        do_write("err_wr", 1, 32'h0000_0204, 32'h0BAD_0002, 2'b11, 1);
        do_read("exok_rd", 0, 32'h0000_0208, 32'h600D_0003, 2'b01, 0);

        // ARREADY stalled 5 cycles; no grant to port 1 while busy
        set_req(0, 1, 0, 32'h0000_5550, 32'h0);
        settle();
        chk("stall_grant", bus.req0_ready, 1);
        cyc();
        set_req(0, 0, 0, 32'h0, 32'h0);
        set_req(1, 1, 0, 32'h0000_6000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_arvalid", bus.arvalid, 1);
            chk("stall_araddr",  bus.araddr, 32'h0000_5550);
            chk("stall_req1_ready", bus.req1_ready, 0);
            cyc();
        end
        chk("stall_arvalid_end", bus.arvalid, 1);
        bus.arready = 1;
        cyc();
        bus.arready = 0;
        set_req(1, 0, 0, 32'h0, 32'h0);
        chk("stall_rready", bus.rready, 1);
        chk("stall_arvalid_drop", bus.arvalid, 0);
        bus.rvalid = 1; bus.rdata = 32'hCAFE_0005; bus.rresp = 2'b00;
        cyc();
        bus.rvalid = 0;
        chk_resp("stall", 0, 32'hCAFE_0005, 0);

        // Reset during RD_DATA abandons the read
        set_req(0, 1, 0, 32'h0000_0700, 32'h0);
        settle();
        chk("abort_grant", bus.req0_ready, 1);
        cyc();
        set_req(0, 0, 0, 32'h0, 32'h0);
        bus.arready = 1;
        cyc();
        bus.arready = 0;
        chk("abort_in_rd_data", bus.rready, 1);
        rst = 1;
        bus.rvalid = 1; bus.rdata = 32'h0000_0BAD;
        cyc();
        rst = 0;
        bus.rvalid = 0;
        chk("abort_rready",  bus.rready, 0);
        chk("abort_arvalid", bus.arvalid, 0);
        chk("abort_no_resp", bus.resp0_valid, 0);
        chk("abort_data_rst", bus.resp0_data, 0);
        cyc();
        chk("abort_still_no_resp", bus.resp0_valid, 0);

        // Pointer back at port 0 after reset
        set_req(0, 1, 0, 32'h0000_0800, 32'h0);
        set_req(1, 1, 0, 32'h0000_0900, 32'h0);
        settle();
        chk("ptr_rst_req0", bus.req0_ready, 1);
        chk("ptr_rst_req1", bus.req1_ready, 0);
        set_req(1, 0, 0, 32'h0, 32'h0);
        do_read("post_rst0", 0, 32'h0000_0800, 32'h0800_0001, 2'b00, 0);
        do_read("post_rst1", 1, 32'h0000_0300, 32'h0300_ABCD, 2'b00, 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
